servo_pwm_array: RTL

Parametrised N-channel hobby-servo PWM generator with per-channel angle registers, frame-synchronous commit and optional slew limiting. Each channel's angle is written individually into a shadow register. A commit request transfers all shadow angles into the live set at the next frame boundary, so an output pulse is never altered mid-frame. It sits between the switch/angle entry logic and the servo output pins, replacing the fixed four-channel controller.

---
 rtl/servo_pwm_array.sv | 130 +++++++++++++
 1 files changed

// File: rtl/servo_pwm_array.sv
// N-channel hobby-servo PWM generator with shadow/live angle sets and frame-synchronous commit.
// Define SERVO_SLEW_EN to rate-limit live angle changes to SLEW_DEG per frame.
module servo_pwm_array #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned FRAME_TICKS   = 1_000_000,
    parameter int unsigned MIN_TICKS     = 27_250,
    parameter int unsigned TICKS_PER_DEG = 515,
    parameter int unsigned MAX_ANGLE     = 180,
    parameter int unsigned RESET_ANGLE   = 90,
    parameter int unsigned SLEW_DEG      = 1,
    localparam int unsigned CHW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CHW-1:0]      wr_ch,
    input  logic [7:0]          wr_angle,
    input  logic                commit,
    output logic [CHANNELS-1:0] servo,
    output logic                frame_tick,
    output logic                wr_clamped,
    output logic                settled
);

    localparam int unsigned CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned PW = CW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_TICKS - 1);
    localparam logic [PW-1:0] FRAME_W  = PW'(FRAME_TICKS);
    localparam logic [PW-1:0] MIN_W    = PW'(MIN_TICKS);
    localparam logic [PW-1:0] TPD_W    = PW'(TICKS_PER_DEG);
    localparam logic [PW-1:0] P_RST    = PW'(MIN_TICKS + RESET_ANGLE * TICKS_PER_DEG);
    localparam logic [7:0]    MAX8     = 8'(MAX_ANGLE);
    localparam logic [7:0]    RST8     = 8'(RESET_ANGLE);
`ifdef SERVO_SLEW_EN
    localparam bit            SLEW_EN  = 1'b1;
`else
    localparam bit            SLEW_EN  = 1'b0;
`endif
    // Without slew limiting a 255-degree step always reaches the target in one frame.
    localparam logic [7:0]    STEP     = SLEW_EN ? 8'(SLEW_DEG) : 8'hFF;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [7:0]          shadow_q [CHANNELS];
    logic [7:0]          shadow_d [CHANNELS];
    logic [7:0]          target_q [CHANNELS];
    logic [7:0]          target_d [CHANNELS];
    logic [7:0]          live_q   [CHANNELS];
    logic [7:0]          live_d   [CHANNELS];
    logic [PW-1:0]       p_q      [CHANNELS];
    logic [PW-1:0]       p_d      [CHANNELS];
    logic                pending_q, pending_d;
    logic [CHANNELS-1:0] servo_q, servo_d;
    logic                frame_tick_q, wr_clamped_q, settled_q, settled_d;
    logic                boundary, wr_ok, all_eq;
    logic [7:0]          wr_val;

    always_comb begin
        boundary  = (cnt_q == CNT_LAST);
        cnt_d     = boundary ? '0 : cnt_q + CW'(1);
        wr_ok     = wr_en && (32'(wr_ch) < CHANNELS);
        wr_val    = (wr_angle > MAX8) ? MAX8 : wr_angle;
        pending_d = pending_q | commit;
        all_eq    = 1'b1;
        servo_d   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = (wr_ok && (32'(wr_ch) == i)) ? wr_val : shadow_q[i];
            target_d[i] = target_q[i];
            live_d[i]   = live_q[i];
            p_d[i]      = p_q[i];
        end
        // The transfer uses shadow_d so a write on the commit boundary cycle is included.
        if (boundary) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (pending_d) begin
                    target_d[i] = shadow_d[i];
                end
                if (target_d[i] > live_q[i]) begin
                    live_d[i] = ((target_d[i] - live_q[i]) > STEP) ? live_q[i] + STEP : target_d[i];
                end else begin
                    live_d[i] = ((live_q[i] - target_d[i]) > STEP) ? live_q[i] - STEP : target_d[i];
                end
                p_d[i] = MIN_W + PW'(live_d[i]) * TPD_W;
            end
            pending_d = 1'b0;
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (live_d[i] != target_d[i]) begin
                all_eq = 1'b0;
            end
            servo_d[i] = (PW'(cnt_d) >= (FRAME_W - p_d[i]));
        end
        settled_d = all_eq && !pending_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            servo_q      <= '0;
            frame_tick_q <= 1'b0;
            wr_clamped_q <= 1'b0;
            settled_q    <= 1'b1;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= RST8;
                target_q[i] <= RST8;
                live_q[i]   <= RST8;
                p_q[i]      <= P_RST;
            end
        end else begin
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            servo_q      <= servo_d;
            frame_tick_q <= (cnt_d == CNT_LAST);
            wr_clamped_q <= wr_ok && (wr_angle > MAX8);
            settled_q    <= settled_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                target_q[i] <= target_d[i];
                live_q[i]   <= live_d[i];
                p_q[i]      <= p_d[i];
            end
        end
    end

    assign servo      = servo_q;
    assign frame_tick = frame_tick_q;
    assign wr_clamped = wr_clamped_q;
    assign settled    = settled_q;

endmodule
